// File: rtl/instr_cache_pkg.sv
// Shared widths and FSM encoding for the direct-mapped instruction cache.
package instr_cache_pkg;
    localparam int INDEX_BITS  = 3;
    localparam int OFFSET_BITS = 4;
    localparam int ADDR_BITS   = 10;
    localparam int TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int BLOCK_BITS  = 128;
    localparam int NUM_LINES   = 1 << INDEX_BITS;
    localparam int WORD_BITS   = OFFSET_BITS - 2;
    localparam int BADDR_BITS  = TAG_BITS + INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_e;
endpackage

// File: rtl/instr_cache_store.sv
// Line store: valid/tag/data arrays, one combinational read port, one clocked write port.
module instr_cache_store
    import instr_cache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [BLOCK_BITS-1:0] rd_data_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [BLOCK_BITS-1:0] wr_data_i
);
    logic [NUM_LINES-1:0]  valid_q;
    logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
    logic [BLOCK_BITS-1:0] data_q [NUM_LINES];

    // Only valid bits are cleared; tag/data contents are masked by valid.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            valid_q <= '0;
        else if (we_i)
            valid_q[wr_index_i] <= 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];
endmodule

// File: rtl/instr_cache.sv
// Read-only direct-mapped I-cache: same-cycle hits, stall and block refill on miss.
module instr_cache
    import instr_cache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           PC,
    output logic [31:0]           INSTRUCTION,
    output logic                  BUSYWAIT,
    output logic                  IMEM_READ,
    output logic [BADDR_BITS-1:0] IMEM_ADDRESS,
    input  logic [BLOCK_BITS-1:0] IMEM_READDATA,
    input  logic                  IMEM_BUSYWAIT
);
    state_e                  state_q, state_d;
    logic [BADDR_BITS-1:0]   baddr_q, baddr_d;
    logic [BLOCK_BITS-1:0]   refill_q, refill_d;

    logic [TAG_BITS-1:0]     pc_tag;
    logic [INDEX_BITS-1:0]   pc_index;
    logic [WORD_BITS-1:0]    pc_word;
    logic                    rd_valid, hit, we, busy;
    logic [TAG_BITS-1:0]     rd_tag;
    logic [BLOCK_BITS-1:0]   rd_data;
    logic                    unused_pc;

    assign pc_tag    = PC[ADDR_BITS-1 -: TAG_BITS];
    assign pc_index  = PC[OFFSET_BITS +: INDEX_BITS];
    assign pc_word   = PC[2 +: WORD_BITS];
    assign unused_pc = ^{PC[31:ADDR_BITS], PC[1:0]};

    instr_cache_store u_store (
        .clk_i      (CLK),
        .rst_n_i    (RESET),
        .rd_index_i (pc_index),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (we),
        .wr_index_i (baddr_q[INDEX_BITS-1:0]),
        .wr_tag_i   (baddr_q[BADDR_BITS-1 -: TAG_BITS]),
        .wr_data_i  (refill_q)
    );

    assign hit         = rd_valid && (rd_tag == pc_tag);
    assign INSTRUCTION = rd_valid ? rd_data[{pc_word, 5'b0} +: 32] : 32'h0;
    // Gate the stall with reset so it drops immediately, not at the next edge.
    assign BUSYWAIT     = busy & RESET;
    assign IMEM_ADDRESS = baddr_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            baddr_q  <= '0;
            refill_q <= '0;
        end else begin
            state_q  <= state_d;
            baddr_q  <= baddr_d;
            refill_q <= refill_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baddr_d   = baddr_q;
        refill_d  = refill_q;
        IMEM_READ = 1'b0;
        busy      = 1'b1;
        we        = 1'b0;
        case (state_q)
            IDLE: begin
                busy = ~hit;
                if (!hit) begin
                    baddr_d = {pc_tag, pc_index};
                    state_d = MEM_READ;
                end
            end
            MEM_READ: begin
                IMEM_READ = 1'b1;
                if (!IMEM_BUSYWAIT) begin
                    refill_d = IMEM_READDATA;
                    state_d  = UPDATE;
                end
            end
            UPDATE: begin
                we      = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache against a fixed-latency block memory model.
module tb_instr_cache;
    localparam int LAT = 5;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [31:0]  PC = 32'h0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         IMEM_READ;
    logic [5:0]   IMEM_ADDRESS;
    logic [127:0] IMEM_READDATA;
    logic         IMEM_BUSYWAIT;

    instr_cache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .PC            (PC),
        .INSTRUCTION   (INSTRUCTION),
        .BUSYWAIT      (BUSYWAIT),
        .IMEM_READ     (IMEM_READ),
        .IMEM_ADDRESS  (IMEM_ADDRESS),
        .IMEM_READDATA (IMEM_READDATA),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [5:0] b, input logic [1:0] w);
        return {16'hC0DE, 2'b00, b, 6'b000000, w};
    endfunction

    // Memory answers in the LAT-th cycle of a continuous read request.
    int cnt;
    always @(posedge CLK or negedge RESET) begin
        if (!RESET)         cnt <= 0;
        else if (IMEM_READ) cnt <= cnt + 1;
        else                cnt <= 0;
    end
    assign IMEM_BUSYWAIT = !(IMEM_READ && cnt == LAT - 1);

    always_comb begin
        IMEM_READDATA = '0;
        for (int w = 0; w < 4; w++)
            IMEM_READDATA[32*w +: 32] = mem_word(IMEM_ADDRESS, w[1:0]);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc);
        @(posedge CLK);
        #1 PC = pc;
    endtask

    // PC already applied; count stall cycles until the instruction is presented.
    task automatic wait_refill(input string name, input logic [31:0] pc,
                               input logic [5:0] baddr, input int nexp);
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        @(negedge CLK);
        while (BUSYWAIT && n < 50) begin
            n++;
            if (IMEM_READ && !seen) begin
                seen = 1;
                chk({name, "_addr"}, {26'b0, IMEM_ADDRESS}, {26'b0, baddr});
                chk({name, "_rd_delay"}, n, 2);
            end
            @(negedge CLK);
        end
        chk({name, "_stall"}, n, nexp);
        chk({name, "_rd_seen"}, {31'b0, seen}, 1);
        chk({name, "_instr"}, INSTRUCTION, mem_word(pc[9:4], pc[3:2]));
    endtask

    task automatic miss_fetch(input string name, input logic [31:0] pc,
                              input logic [5:0] baddr, input int nexp);
        drive(pc);
        wait_refill(name, pc, baddr, nexp);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        busy;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs [9];

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vecs[i].pc);
            @(negedge CLK);
            chk($sformatf("vec%0d_busy", i), {31'b0, BUSYWAIT}, {31'b0, vecs[i].busy});
            chk($sformatf("vec%0d_instr", i), INSTRUCTION, vecs[i].instr);
            chk($sformatf("vec%0d_rd", i), {31'b0, IMEM_READ}, 0);
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{32'h004, 1'b0, mem_word(6'd0, 2'd1)};
        vecs[1] = '{32'h008, 1'b0, mem_word(6'd0, 2'd2)};
        vecs[2] = '{32'h00C, 1'b0, mem_word(6'd0, 2'd3)};
        vecs[3] = '{32'h014, 1'b0, mem_word(6'd1, 2'd1)};
        vecs[4] = '{32'h020, 1'b0, mem_word(6'd2, 2'd0)};
        vecs[5] = '{32'h01C, 1'b0, mem_word(6'd1, 2'd3)};
        vecs[6] = '{32'h000, 1'b0, mem_word(6'd0, 2'd0)};
        vecs[7] = '{32'h030, 1'b0, mem_word(6'd3, 2'd0)};
        vecs[8] = '{32'h044, 1'b0, mem_word(6'd4, 2'd1)};

        // Reset state
        #12;
        chk("rst_busy", {31'b0, BUSYWAIT}, 0);
        chk("rst_read", {31'b0, IMEM_READ}, 0);
        chk("rst_instr", INSTRUCTION, 0);

        // Cold miss, then spatial hits
        @(posedge CLK);
        #1 PC = 32'h0; RESET = 1'b1;
        wait_refill("cold", 32'h000, 6'd0, LAT + 2);
        apply(0, 2);

        // Conflict misses on index 0
        miss_fetch("conf_t1", 32'h080, 6'd8, LAT + 2);
        miss_fetch("conf_t0", 32'h000, 6'd0, LAT + 2);

        // Distinct indices coexist
        miss_fetch("idx1", 32'h010, 6'd1, LAT + 2);
        miss_fetch("idx2", 32'h028, 6'd2, LAT + 2);
        apply(3, 6);

        // PC wiggle during refill
        drive(32'h030);
        @(negedge CLK);
        chk("wig_miss", {31'b0, BUSYWAIT}, 1);
        drive(32'h040);
        @(negedge CLK);
        chk("wig_rd", {31'b0, IMEM_READ}, 1);
        chk("wig_addr", {26'b0, IMEM_ADDRESS}, 32'd3);
        n = 0;
        while (IMEM_READ && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("wig_rd_cycles", n, LAT);
        chk("wig_upd_busy", {31'b0, BUSYWAIT}, 1);
        @(negedge CLK);
        chk("wig_idle_busy", {31'b0, BUSYWAIT}, 1);
        chk("wig_idle_rd", {31'b0, IMEM_READ}, 0);
        @(negedge CLK);
        chk("wig2_rd", {31'b0, IMEM_READ}, 1);
        chk("wig2_addr", {26'b0, IMEM_ADDRESS}, 32'd4);
        n = 0;
        while (BUSYWAIT && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("wig2_stall", n, LAT + 1);
        chk("wig2_instr", INSTRUCTION, mem_word(6'd4, 2'd0));
        apply(7, 8);

        // Reset mid-refill
        drive(32'h100);
        @(negedge CLK);
        @(negedge CLK);
        chk("rmid_rd", {31'b0, IMEM_READ}, 1);
        chk("rmid_addr", {26'b0, IMEM_ADDRESS}, 32'h10);
        #2 RESET = 1'b0;
        #1;
        chk("rmid_rd_drop", {31'b0, IMEM_READ}, 0);
        chk("rmid_busy_drop", {31'b0, BUSYWAIT}, 0);
        chk("rmid_instr", INSTRUCTION, 0);
        @(posedge CLK);
        @(posedge CLK);
        #1 PC = 32'h0; RESET = 1'b1;
        wait_refill("post_rst", 32'h000, 6'd0, LAT + 2);
        miss_fetch("post_rst_idx1", 32'h010, 6'd1, LAT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port (PC in, INSTRUCTION out) and a block-wide instruction memory.
- Replaces the fixed-delay combinational fetch array.
- Hits return the instruction in the same cycle as the PC is presented.
- Misses stall the CPU through BUSYWAIT while a 16-byte block is refilled.

Parameters:
INDEX_BITS, 3, log2 of number of lines (8 lines)
OFFSET_BITS, 4, log2 of block size in bytes (16 B = 4 instructions)
ADDR_BITS, 10, byte-address bits used from PC (1024-byte instruction space); tag width = ADDR_BITS-INDEX_BITS-OFFSET_BITS = 3

Ports:
CLK  in  1  clock, all state updates on posedge
RESET  in  1  asynchronous, active-low reset (0 = reset asserted)
PC  in  32  fetch byte address from CPU; only PC[9:0] used, PC[1:0] ignored
INSTRUCTION  out  32  fetched instruction word
BUSYWAIT  out  1  stall to CPU; 1 = INSTRUCTION not valid, PC must be held
IMEM_READ  out  1  block read request to instruction memory
IMEM_ADDRESS  out  6  block address {tag,index} = PC[9:4] of the missing block
IMEM_READDATA  in  128  refill block; byte 0 in bits [7:0], word w in bits [32w+31:32w]
IMEM_BUSYWAIT  in  1  memory busy; deassertion with IMEM_READ high means IMEM_READDATA valid this cycle

Behaviour:
- Address split: tag = PC[9:7], index = PC[6:4], word = PC[3:2].
- Line store per index: valid (1 b), tag (3 b), data (128 b). No dirty bits; the cache never writes memory.
- Hit = valid[index] & (tag[index] == PC tag), combinational from PC.
- INSTRUCTION = data[index] word `word`, combinational. Value is don't-care when BUSYWAIT=1; drive 32'h0 while the line is invalid.
- States: IDLE, MEM_READ, UPDATE. Encoding lives in the shared package.
- IDLE:
  - BUSYWAIT = ~hit. IMEM_READ = 0.
  - On posedge with miss, go to MEM_READ and latch the miss block address {tag,index} into an internal register.
- MEM_READ:
  - BUSYWAIT = 1. IMEM_READ = 1. IMEM_ADDRESS = latched block address.
  - Stay while IMEM_BUSYWAIT = 1.
  - On posedge with IMEM_BUSYWAIT = 0, capture IMEM_READDATA into a refill register and go to UPDATE.
- UPDATE:
  - BUSYWAIT = 1. IMEM_READ = 0.
  - On posedge, write refill data, the latched tag and valid = 1 into the latched index, then go to IDLE.
- Miss latency: miss detected in cycle 0. The line is valid and BUSYWAIT drops in the IDLE cycle after UPDATE, i.e. memory latency + 2 cycles.
- PC changing during MEM_READ/UPDATE is ignored; the refill completes for the latched address. Back in IDLE, hit/miss is re-evaluated on the current PC.
- Replacement: a conflict miss overwrites the line unconditionally; no write-back.
- IMEM_ADDRESS in IDLE/UPDATE = latched block address; it is only sampled while IMEM_READ=1.
- Reset (RESET=0, asynchronous):
  - All valid bits cleared. State = IDLE. IMEM_READ = 0. BUSYWAIT = 0. INSTRUCTION = 0. Refill and latched-address registers cleared.
  - Reset mid-refill aborts immediately; the partially fetched line is not written.
- Data and tag arrays need not be reset; only valid bits are architecturally required to clear.
- A back-to-back miss after UPDATE re-enters MEM_READ on the next posedge with no extra idle cycle beyond the one IDLE evaluation cycle.

Decomposition:
- Shared package (instr_cache_pkg):
  - State encoding constants IDLE=2'd0, MEM_READ=2'd1, UPDATE=2'd2.
  - Field widths TAG_BITS, INDEX_BITS, OFFSET_BITS, BLOCK_BITS=128.
- One natural sub-module: instr_cache_store.
  - Holds the valid/tag/data arrays with async-clear valid.
  - One combinational read port (index) and one synchronous write port (index, tag, data, we).
- The top level holds the FSM, address latch, hit compare and word select.

Test Plan:
- Cold miss: release reset, PC=0, memory model latency 5 cycles, block 0 = words {w0..w3} → IMEM_READ=1 with IMEM_ADDRESS=6'd0 one cycle after miss; BUSYWAIT=1 for 7 cycles; then INSTRUCTION=w0, BUSYWAIT=0.
- Spatial hits: after the cold miss, PC=4, 8, 12 on consecutive cycles → BUSYWAIT stays 0, INSTRUCTION=w1, w2, w3 the same cycle; IMEM_READ never asserts.
- Conflict miss: PC=0x080 (tag 1, index 0) → refill with IMEM_ADDRESS=6'd8 and correct new word; then PC=0x000 → miss again, IMEM_ADDRESS=6'd0.
- Distinct indices: fill PC=0x010 and 0x020, then revisit both → both hit, no IMEM_READ.
- PC wiggle during refill: change PC from 0x030 to 0x040 while in MEM_READ → IMEM_ADDRESS stays 6'd3, line 3 is filled; on return to IDLE, miss on 0x040 starts with IMEM_ADDRESS=6'd4.
- Reset mid-refill: pull RESET low during MEM_READ → IMEM_READ and BUSYWAIT drop without waiting for a clock; after release, PC=0 misses again (valid cleared) and refill restarts.
